// File: rtl/sync_size_meas.sv
// Measures active lines, active pixels/line and clocks/line from vs/hs/de; publishes after STABLE_FRAMES matching frames.
// Latency: results/pulses registered on the 2nd edge after vs_in samples low. Optional macro: SYNC_SIZE_MEAS_VTOTAL_EN.
module sync_size_meas #(
  parameter int ROW_W         = 11,
  parameter int COL_W         = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             de_in,
  output logic [ROW_W-1:0] row_size,
  output logic [COL_W-1:0] col_size,
  output logic [COL_W-1:0] htotal,
  output logic             meas_valid,
  output logic             size_change,
  output logic             frame_err,
  output logic             frame_done
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
  ,
  output logic [ROW_W-1:0] vtotal
`endif
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  logic             r_vs_d1, r_vs_d2, r_hs_d1, r_hs_d2, r_de_d1, r_de_d2;
  logic             r_armed, r_bad;
  logic [ROW_W-1:0] r_line_cnt, r_cand_row;
  logic [COL_W-1:0] r_pix_cnt, r_hclk_cnt, r_htot_last, r_ref_col;
  logic [COL_W-1:0] r_cand_col, r_cand_ht;
  logic [3:0]       r_stable_cnt;
  logic             w_vs_rise, w_vs_fall, w_hs_rise, w_de_rise, w_de_fall;
  logic             w_cand_eq, w_pub_eq, w_bad;
  logic [3:0]       w_stable_nxt;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
  logic [ROW_W-1:0] r_vcnt, r_vt_last, r_cand_vt;
  logic             r_vs_seen, r_vt_known;
`endif

  assign w_vs_rise = r_vs_d1 & ~r_vs_d2;
  assign w_vs_fall = ~r_vs_d1 & r_vs_d2;
  assign w_hs_rise = r_hs_d1 & ~r_hs_d2;
  assign w_de_rise = r_de_d1 & ~r_de_d2;
  assign w_de_fall = ~r_de_d1 & r_de_d2;

  always_comb begin
    w_cand_eq = (r_line_cnt == r_cand_row) && (r_ref_col == r_cand_col) &&
                (r_htot_last == r_cand_ht);
    w_pub_eq  = (r_line_cnt == row_size) && (r_ref_col == col_size) &&
                (r_htot_last == htotal);
    w_bad     = r_bad || (r_line_cnt == '0);
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
    w_cand_eq = w_cand_eq && (r_vt_last == r_cand_vt);
    w_pub_eq  = w_pub_eq && (r_vt_last == vtotal);
    w_bad     = w_bad || !r_vt_known;
`endif
    if (!w_cand_eq)
      w_stable_nxt = 4'd1;
    else if (r_stable_cnt >= SF)
      w_stable_nxt = SF;
    else
      w_stable_nxt = r_stable_cnt + 4'd1;
  end

  // Front end: synchronisers and per-frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // vs history starts high so a vs_in already high at reset release is not seen as a rise.
      r_vs_d1     <= 1'b1;
      r_vs_d2     <= 1'b1;
      r_hs_d1     <= 1'b0;
      r_hs_d2     <= 1'b0;
      r_de_d1     <= 1'b0;
      r_de_d2     <= 1'b0;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_hclk_cnt  <= '0;
      r_htot_last <= '0;
      r_ref_col   <= '0;
      r_bad       <= 1'b0;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
      r_vcnt      <= '0;
      r_vt_last   <= '0;
      r_vs_seen   <= 1'b0;
      r_vt_known  <= 1'b0;
`endif
    end else begin
      r_vs_d1 <= vs_in;
      r_vs_d2 <= r_vs_d1;
      r_hs_d1 <= hs_in;
      r_hs_d2 <= r_hs_d1;
      r_de_d1 <= de_in;
      r_de_d2 <= r_de_d1;

      if (r_vs_d1 && w_hs_rise) begin
        r_htot_last <= r_hclk_cnt;
        r_hclk_cnt  <= COL_W'(1);
      end else if (r_vs_d1 && (r_hclk_cnt != '1)) begin
        r_hclk_cnt <= r_hclk_cnt + COL_W'(1);
      end

      if (w_vs_rise) begin
        r_line_cnt <= '0;
        r_pix_cnt  <= '0;
        r_ref_col  <= '0;
        r_bad      <= 1'b0;
      end else if (r_vs_d1) begin
        if (w_de_rise && (r_line_cnt != '1))
          r_line_cnt <= r_line_cnt + ROW_W'(1);
        if (w_de_rise)
          r_pix_cnt <= COL_W'(1);
        else if (r_de_d1 && (r_pix_cnt != '1))
          r_pix_cnt <= r_pix_cnt + COL_W'(1);
        if (w_de_fall) begin
          if (r_line_cnt == ROW_W'(1))
            r_ref_col <= r_pix_cnt;
          else if (r_pix_cnt != r_ref_col)
            r_bad <= 1'b1;
        end
        if ((r_line_cnt == '1) || (r_pix_cnt == '1) || (r_hclk_cnt == '1))
          r_bad <= 1'b1;
      end

`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
      if (w_vs_rise) begin
        r_vt_last  <= r_vcnt;
        r_vcnt     <= w_hs_rise ? ROW_W'(1) : '0;
        r_vs_seen  <= 1'b1;
        r_vt_known <= r_vs_seen;
      end else if (w_hs_rise && (r_vcnt != '1)) begin
        r_vcnt <= r_vcnt + ROW_W'(1);
      end
`endif
    end
  end

  // Frame-end decision: stability tracking, publishing and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed      <= 1'b0;
      r_stable_cnt <= '0;
      r_cand_row   <= '0;
      r_cand_col   <= '0;
      r_cand_ht    <= '0;
      row_size     <= '0;
      col_size     <= '0;
      htotal       <= '0;
      meas_valid   <= 1'b0;
      size_change  <= 1'b0;
      frame_err    <= 1'b0;
      frame_done   <= 1'b0;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
      r_cand_vt    <= '0;
      vtotal       <= '0;
`endif
    end else begin
      size_change <= 1'b0;
      frame_err   <= 1'b0;
      frame_done  <= 1'b0;
      if (w_vs_rise)
        r_armed <= 1'b1;
      if (w_vs_fall && r_armed) begin
        frame_done <= 1'b1;
        if (w_bad) begin
          frame_err    <= 1'b1;
          r_stable_cnt <= '0;
          meas_valid   <= 1'b0;
        end else begin
          r_stable_cnt <= w_stable_nxt;
          if (!w_cand_eq) begin
            r_cand_row <= r_line_cnt;
            r_cand_col <= r_ref_col;
            r_cand_ht  <= r_htot_last;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
            r_cand_vt  <= r_vt_last;
`endif
          end
          if (meas_valid && !w_pub_eq) begin
            size_change <= 1'b1;
            meas_valid  <= 1'b0;
          end
          if (w_stable_nxt == SF) begin
            row_size   <= r_line_cnt;
            col_size   <= r_ref_col;
            htotal     <= r_htot_last;
            meas_valid <= 1'b1;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
            vtotal     <= r_vt_last;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_size_meas.sv
// Directed bench for sync_size_meas: frame generator, pulse counters, immediate-assert checks.
module tb_sync_size_meas;
  logic        clk = 1'b0;
  logic        rst, vs_in, hs_in, de_in;
  logic [10:0] row_size;
  logic [11:0] col_size, htotal;
  logic        meas_valid, size_change, frame_err, frame_done;
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
  logic [10:0] vtotal;
`endif
  int n_checks = 0;
  int n_fail   = 0;
  int sc_tot = 0, fe_tot = 0, fd_tot = 0;

  always #5 clk = ~clk;

  sync_size_meas #(.ROW_W(11), .COL_W(12), .STABLE_FRAMES(2)) dut (
`ifdef SYNC_SIZE_MEAS_VTOTAL_EN
    .vtotal(vtotal),
`endif
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .row_size(row_size), .col_size(col_size), .htotal(htotal),
    .meas_valid(meas_valid), .size_change(size_change),
    .frame_err(frame_err), .frame_done(frame_done)
  );

  always @(posedge clk) begin
    if (size_change) sc_tot++;
    if (frame_err)   fe_tot++;
    if (frame_done)  fd_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: nhs lines of htot clocks, hs high 2 clks, de for npix clks in the first nact lines.
  task automatic frame(input string tag, input int nact, input int npix, input int htot,
                       input int nhs, input int bad_line, input int rst_line);
    vs_in = 1'b1;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nhs; l++) begin
      if (l == rst_line) begin
        hs_in = 1'b0; de_in = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, ".rst_row"}, 32'(row_size), 0);
        chk({tag, ".rst_col"}, 32'(col_size), 0);
        chk({tag, ".rst_ht"},  32'(htotal), 0);
        chk({tag, ".rst_mv"},  32'(meas_valid), 0);
        rst = 1'b0;
      end
      for (int c = 0; c < htot; c++) begin
        hs_in = (c < 2);
        de_in = (l < nact) && (c >= 4) && (c < 4 + ((l == bad_line) ? npix - 1 : npix));
        @(negedge clk);
      end
    end
    hs_in = 1'b0; de_in = 1'b0; vs_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic run(input string tag, input int nact, input int npix, input int htot,
                     input int nhs, input int bad_line, input int rst_line,
                     input int e_mv, input int e_row, input int e_col, input int e_ht,
                     input int e_fe, input int e_sc, input int e_fd);
    int sc0, fe0, fd0;
    sc0 = sc_tot; fe0 = fe_tot; fd0 = fd_tot;
    frame(tag, nact, npix, htot, nhs, bad_line, rst_line);
    chk({tag, ".meas_valid"},  32'(meas_valid), 32'(e_mv));
    chk({tag, ".row_size"},    32'(row_size), 32'(e_row));
    chk({tag, ".col_size"},    32'(col_size), 32'(e_col));
    chk({tag, ".htotal"},      32'(htotal), 32'(e_ht));
    chk({tag, ".frame_err"},   32'(fe_tot - fe0), 32'(e_fe));
    chk({tag, ".size_change"}, 32'(sc_tot - sc0), 32'(e_sc));
    chk({tag, ".frame_done"},  32'(fd_tot - fd0), 32'(e_fd));
  endtask

  initial begin
    rst = 1'b1; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset.row_size",   32'(row_size), 0);
    chk("reset.col_size",   32'(col_size), 0);
    chk("reset.htotal",     32'(htotal), 0);
    chk("reset.meas_valid", 32'(meas_valid), 0);
    chk("reset.pulses",     32'(sc_tot + fe_tot + fd_tot), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset.pulses", 32'(sc_tot + fe_tot + fd_tot), 0);
`ifndef SYNC_SIZE_MEAS_VTOTAL_EN
    run("t1f1", 8, 16, 24, 8, -1, -1,   0, 0, 0, 0,     0, 0, 1);
    run("t1f2", 8, 16, 24, 8, -1, -1,   1, 8, 16, 24,   0, 0, 1);
    run("t1f3", 8, 16, 24, 8, -1, -1,   1, 8, 16, 24,   0, 0, 1);
    run("t2f1", 10, 20, 30, 10, -1, -1, 0, 8, 16, 24,   0, 1, 1);
    run("t2f2", 10, 20, 30, 10, -1, -1, 1, 10, 20, 30,  0, 0, 1);
    run("t3bad", 10, 20, 30, 10, 3, -1, 0, 10, 20, 30,  1, 0, 1);
    run("t3f1", 10, 20, 30, 10, -1, -1, 0, 10, 20, 30,  0, 0, 1);
    run("t3f2", 10, 20, 30, 10, -1, -1, 1, 10, 20, 30,  0, 0, 1);
    run("t4rst", 8, 16, 24, 8, -1, 2,   0, 0, 0, 0,     0, 0, 0);
    run("t4f1", 8, 16, 24, 8, -1, -1,   0, 0, 0, 0,     0, 0, 1);
    run("t4f2", 8, 16, 24, 8, -1, -1,   1, 8, 16, 24,   0, 0, 1);
    run("t5nde", 0, 16, 24, 8, -1, -1,  0, 8, 16, 24,   1, 0, 1);
    run("t5f1", 8, 16, 24, 8, -1, -1,   0, 8, 16, 24,   0, 0, 1);
`else
    run("t6f1", 8, 16, 24, 12, -1, -1,  0, 0, 0, 0,     1, 0, 1);
    chk("t6f1.vtotal", 32'(vtotal), 0);
    run("t6f2", 8, 16, 24, 12, -1, -1,  0, 0, 0, 0,     0, 0, 1);
    run("t6f3", 8, 16, 24, 12, -1, -1,  1, 8, 16, 24,   0, 0, 1);
    chk("t6f3.vtotal", 32'(vtotal), 12);
    run("t6f4", 8, 16, 24, 13, -1, -1,  1, 8, 16, 24,   0, 0, 1);
    chk("t6f4.vtotal", 32'(vtotal), 12);
    run("t6f5", 8, 16, 24, 13, -1, -1,  0, 8, 16, 24,   0, 1, 1);
    chk("t6f5.vtotal", 32'(vtotal), 12);
    run("t6f6", 8, 16, 24, 13, -1, -1,  1, 8, 16, 24,   0, 0, 1);
    chk("t6f6.vtotal", 32'(vtotal), 13);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
